c7b_biu: RTL and testbench
==========================

C7B_BIU -- requirements
Module: c7b_biu

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-002 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports lsu_biu_rd_req_ls2 in 1, lsu_biu_rd_addr_ls2 in 32  LSU read request (level, held until ack) and byte address.
REQ-004 SHALL have ports biu_lsu_rd_ack_ls2 out 1, biu_lsu_data_valid_ls3 out 1, biu_lsu_data_ls3 out 64, biu_lsu_rd_err_ls3 out 1  read accept pulse, read data pulse, 64-bit beat, bus error with data pulse.
REQ-005 SHALL have ports lsu_biu_wr_req_ls2 in 1, lsu_biu_wr_addr_ls2 in 32, lsu_biu_wr_data_ls2 in 64, lsu_biu_wr_strb_ls2 in 8  LSU write request (level, held until ack), address, data, byte strobes.
REQ-006 SHALL have ports biu_lsu_wr_ack_ls2 out 1, biu_lsu_wr_done_ls3 out 1, biu_lsu_wr_err_ls3 out 1  write accept pulse, completion pulse, error with completion.
REQ-007 SHALL have ports biu_mem_req out 1, biu_mem_we out 1, biu_mem_addr out 32, biu_mem_wdata out 64, biu_mem_wstrb out 8  memory-side request, held until mem_biu_gnt.
REQ-008 SHALL have ports mem_biu_gnt in 1, mem_biu_rvalid in 1, mem_biu_rdata in 64, mem_biu_err in 1  grant, response valid (reads and writes), read data, error qualifier of rvalid.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, RESP; exactly one transaction outstanding.
REQ-010 IDLE: if rd_req, SHALL capture address with [2:0] forced to 0, we=0, go REQ next cycle; else if wr_req, SHALL capture address unmodified, data, strobe, we=1, go REQ.
REQ-011 Read SHALL win when rd_req and wr_req both high in IDLE; write remains pending, serviced next IDLE.
REQ-012 REQ: biu_mem_req=1 with captured fields stable; on mem_biu_gnt SHALL pulse rd_ack or wr_ack (per we) for exactly that cycle and go RESP.
REQ-013 RESP: biu_mem_req=0; on mem_biu_rvalid SHALL register rdata/err and go IDLE.
REQ-014 Read completion: biu_lsu_data_valid_ls3 SHALL pulse one cycle, the cycle after rvalid, with biu_lsu_data_ls3=registered rdata, biu_lsu_rd_err_ls3=registered err.
REQ-015 Write completion: biu_lsu_wr_done_ls3 SHALL pulse one cycle after rvalid, biu_lsu_wr_err_ls3=registered err; data output unchanged.
REQ-016 Minimum latency rd_req rise to data_valid SHALL be 3 cycles when gnt and rvalid arrive on first possible cycles (IDLE->REQ, gnt in REQ, rvalid first RESP cycle, pulse next).
REQ-017 New request SHALL be sampled in the IDLE cycle coinciding with a completion pulse (back-to-back allowed).
REQ-018 rvalid in IDLE/REQ and gnt outside REQ SHALL be ignored.
REQ-019 biu_lsu_data_ls3 SHALL hold last read beat between pulses.

Reset
REQ-020 resetn low SHALL force IDLE immediately, all outputs 0 (including data 0), captured registers 0.
REQ-021 Reset mid-transaction SHALL abandon it with no ack/done pulse; first request after release serviced normally.

Configuration
REQ-022 Macro C7B_BIU_TIMEOUT_EN defined: 8-bit counter clears on entering RESP, increments each RESP cycle without rvalid; at 255 SHALL complete as if rvalid with err=1, data 0.
REQ-023 Macro undefined: no counter; RESP waits indefinitely for rvalid.

Verification
REQ-024 Read: rd_addr=0x1004, gnt in 1st REQ cycle, rvalid next cycle rdata=0x123456789ABCDEF0 -> biu_mem_addr=0x1000, we=0, one ack pulse, data_valid 3 cycles after req, data=0x123456789ABCDEF0, rd_err=0.
REQ-025 Write: wr_addr=0x2002, data=0xAA0000, strb=0x04, gnt delayed 3 cycles, rvalid 2 later -> mem_req held 4 cycles, addr=0x2002, we=1, wstrb=0x04, one wr_ack, one wr_done, wr_err=0.
REQ-026 Simultaneous rd_req 0x3000 and wr_req 0x4000 in IDLE -> read issued first, write issued in IDLE after read completion; exactly one pulse each of rd_ack, data_valid, wr_ack, wr_done.
REQ-027 Read with mem_biu_err=1 on rvalid -> data_valid and rd_err pulse together; FSM returns IDLE.
REQ-028 resetn low during RESP, then rvalid -> no data_valid, all outputs 0; subsequent read completes normally.
REQ-029 With C7B_BIU_TIMEOUT_EN, no rvalid after gnt -> data_valid with rd_err=1 and data 0 after 255 RESP cycles; without macro, no completion after 1000 cycles.

Source files
------------

// File: rtl/c7b_biu_if.sv
// ---------------------------------------------------------------------------
// c7b_biu_if -- signal bundle between the load/store unit, the bus interface
// unit and the memory port.
//
// Groups:
//   LSU read  : lsu_biu_rd_req_ls2, lsu_biu_rd_addr_ls2 (to BIU)
//               biu_lsu_rd_ack_ls2, biu_lsu_data_valid_ls3,
//               biu_lsu_data_ls3, biu_lsu_rd_err_ls3 (from BIU)
//   LSU write : lsu_biu_wr_req_ls2, lsu_biu_wr_addr_ls2,
//               lsu_biu_wr_data_ls2, lsu_biu_wr_strb_ls2 (to BIU)
//               biu_lsu_wr_ack_ls2, biu_lsu_wr_done_ls3,
//               biu_lsu_wr_err_ls3 (from BIU)
//   Memory    : biu_mem_req, biu_mem_we, biu_mem_addr, biu_mem_wdata,
//               biu_mem_wstrb (from BIU)
//               mem_biu_gnt, mem_biu_rvalid, mem_biu_rdata,
//               mem_biu_err (to BIU)
//
// Modports:
//   slave  : the BIU itself
//   master : the environment driving the LSU and memory sides
// ---------------------------------------------------------------------------
interface c7b_biu_if;
    logic        lsu_biu_rd_req_ls2;
    logic [31:0] lsu_biu_rd_addr_ls2;
    logic        biu_lsu_rd_ack_ls2;
    logic        biu_lsu_data_valid_ls3;
    logic [63:0] biu_lsu_data_ls3;
    logic        biu_lsu_rd_err_ls3;

    logic        lsu_biu_wr_req_ls2;
    logic [31:0] lsu_biu_wr_addr_ls2;
    logic [63:0] lsu_biu_wr_data_ls2;
    logic [7:0]  lsu_biu_wr_strb_ls2;
    logic        biu_lsu_wr_ack_ls2;
    logic        biu_lsu_wr_done_ls3;
    logic        biu_lsu_wr_err_ls3;

    logic        biu_mem_req;
    logic        biu_mem_we;
    logic [31:0] biu_mem_addr;
    logic [63:0] biu_mem_wdata;
    logic [7:0]  biu_mem_wstrb;

    logic        mem_biu_gnt;
    logic        mem_biu_rvalid;
    logic [63:0] mem_biu_rdata;
    logic        mem_biu_err;

    modport slave (
        input  lsu_biu_rd_req_ls2, lsu_biu_rd_addr_ls2,
        output biu_lsu_rd_ack_ls2, biu_lsu_data_valid_ls3,
        output biu_lsu_data_ls3, biu_lsu_rd_err_ls3,
        input  lsu_biu_wr_req_ls2, lsu_biu_wr_addr_ls2,
        input  lsu_biu_wr_data_ls2, lsu_biu_wr_strb_ls2,
        output biu_lsu_wr_ack_ls2, biu_lsu_wr_done_ls3, biu_lsu_wr_err_ls3,
        output biu_mem_req, biu_mem_we, biu_mem_addr,
        output biu_mem_wdata, biu_mem_wstrb,
        input  mem_biu_gnt, mem_biu_rvalid, mem_biu_rdata, mem_biu_err
    );

    modport master (
        output lsu_biu_rd_req_ls2, lsu_biu_rd_addr_ls2,
        input  biu_lsu_rd_ack_ls2, biu_lsu_data_valid_ls3,
        input  biu_lsu_data_ls3, biu_lsu_rd_err_ls3,
        output lsu_biu_wr_req_ls2, lsu_biu_wr_addr_ls2,
        output lsu_biu_wr_data_ls2, lsu_biu_wr_strb_ls2,
        input  biu_lsu_wr_ack_ls2, biu_lsu_wr_done_ls3, biu_lsu_wr_err_ls3,
        input  biu_mem_req, biu_mem_we, biu_mem_addr,
        input  biu_mem_wdata, biu_mem_wstrb,
        output mem_biu_gnt, mem_biu_rvalid, mem_biu_rdata, mem_biu_err
    );
endinterface

// File: rtl/c7b_biu.sv
// ---------------------------------------------------------------------------
// c7b_biu -- single-outstanding bus interface unit between the LSU and a
// request/grant/response memory port.
//
// Ports:
//   clk    : sole clock, all state updates on the rising edge
//   resetn : asynchronous active-low reset
//   bus    : c7b_biu_if.slave, LSU read/write channels and memory port
//
// A read or write request is captured in IDLE (reads win, read address is
// forced to 8-byte alignment), presented on the memory port in REQ until
// granted (ack pulses in the grant cycle), and completed in RESP when the
// response arrives; the completion pulse appears one cycle later.
//
// Optional feature: define C7B_BIU_TIMEOUT_EN to add an 8-bit RESP timeout
// that completes the transaction with an error if no response arrives.
// ---------------------------------------------------------------------------
module c7b_biu (
    input logic      clk,
    input logic      resetn,
    c7b_biu_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [63:0] rdata_q, rdata_d;
    logic        rdValid_q, rdValid_d;
    logic        rdErr_q, rdErr_d;
    logic        wrDone_q, wrDone_d;
    logic        wrErr_q, wrErr_d;
    logic        rdAck, wrAck;
`ifdef C7B_BIU_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
`endif

    // State and captured transaction registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            rdValid_q <= 1'b0;
            rdErr_q   <= 1'b0;
            wrDone_q  <= 1'b0;
            wrErr_q   <= 1'b0;
`ifdef C7B_BIU_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            rdValid_q <= rdValid_d;
            rdErr_q   <= rdErr_d;
            wrDone_q  <= wrDone_d;
            wrErr_q   <= wrErr_d;
`ifdef C7B_BIU_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Next-state logic; completion pulses and errors default low so they
    // last exactly one cycle, while read data holds until the next read.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        rdValid_d = 1'b0;
        rdErr_d   = 1'b0;
        wrDone_d  = 1'b0;
        wrErr_d   = 1'b0;
        rdAck     = 1'b0;
        wrAck     = 1'b0;
`ifdef C7B_BIU_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.lsu_biu_rd_req_ls2) begin
                    addr_d  = {bus.lsu_biu_rd_addr_ls2[31:3], 3'b000};
                    we_d    = 1'b0;
                    state_d = REQ;
                end else if (bus.lsu_biu_wr_req_ls2) begin
                    addr_d  = bus.lsu_biu_wr_addr_ls2;
                    wdata_d = bus.lsu_biu_wr_data_ls2;
                    wstrb_d = bus.lsu_biu_wr_strb_ls2;
                    we_d    = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_biu_gnt) begin
                    rdAck   = !we_q;
                    wrAck   = we_q;
                    state_d = RESP;
`ifdef C7B_BIU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            RESP: begin
                if (bus.mem_biu_rvalid) begin
                    state_d = IDLE;
                    if (we_q) begin
                        wrDone_d = 1'b1;
                        wrErr_d  = bus.mem_biu_err;
                    end else begin
                        rdValid_d = 1'b1;
                        rdErr_d   = bus.mem_biu_err;
                        rdata_d   = bus.mem_biu_rdata;
                    end
                end
`ifdef C7B_BIU_TIMEOUT_EN
                // A missing response becomes an error completion, data 0.
                else if (cnt_q == 8'hFF) begin
                    state_d = IDLE;
                    if (we_q) begin
                        wrDone_d = 1'b1;
                        wrErr_d  = 1'b1;
                    end else begin
                        rdValid_d = 1'b1;
                        rdErr_d   = 1'b1;
                        rdata_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.biu_mem_req            = (state_q == REQ);
    assign bus.biu_mem_we             = we_q;
    assign bus.biu_mem_addr           = addr_q;
    assign bus.biu_mem_wdata          = wdata_q;
    assign bus.biu_mem_wstrb          = wstrb_q;
    assign bus.biu_lsu_rd_ack_ls2     = rdAck;
    assign bus.biu_lsu_wr_ack_ls2     = wrAck;
    assign bus.biu_lsu_data_valid_ls3 = rdValid_q;
    assign bus.biu_lsu_data_ls3       = rdata_q;
    assign bus.biu_lsu_rd_err_ls3     = rdErr_q;
    assign bus.biu_lsu_wr_done_ls3    = wrDone_q;
    assign bus.biu_lsu_wr_err_ls3     = wrErr_q;

endmodule

// File: tb/tb_c7b_biu.sv
// ---------------------------------------------------------------------------
// tb_c7b_biu -- self-checking bench for c7b_biu: a table of directed read and
// write transactions with hand-computed results, plus hand-written sequences
// for read/write contention, reset during RESP and the missing response.
// ---------------------------------------------------------------------------
module tb_c7b_biu;

    logic clk;
    logic resetn;

    c7b_biu_if bus ();

    c7b_biu dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [63:0] rdata;
        logic        err;
        int          gntDelay;
        int          rvDelay;
        logic        noise;
        logic [31:0] expAddr;
        logic [63:0] expData;
        logic        expErr;
    } vecT;

    vecT vecs [5];

    int checks;
    int passes;

    logic [31:0] obsAddr;
    logic        obsWe;
    logic [63:0] obsWdata;
    logic [7:0]  obsStrb;
    logic [63:0] obsData;
    logic        obsErr;
    logic        fieldChanged;
    logic        timedOut;
    int          reqCycles;
    int          ackCnt;
    int          wrongAckCnt;
    int          doneCnt;
    int          wrongDoneCnt;
    int          extraPulse;
    int          latency;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic idleInputs();
        bus.lsu_biu_rd_req_ls2  = 1'b0;
        bus.lsu_biu_rd_addr_ls2 = '0;
        bus.lsu_biu_wr_req_ls2  = 1'b0;
        bus.lsu_biu_wr_addr_ls2 = '0;
        bus.lsu_biu_wr_data_ls2 = '0;
        bus.lsu_biu_wr_strb_ls2 = '0;
        bus.mem_biu_gnt         = 1'b0;
        bus.mem_biu_rvalid      = 1'b0;
        bus.mem_biu_rdata       = '0;
        bus.mem_biu_err         = 1'b0;
    endtask

    // Runs one transaction: raises the LSU request, grants after gntDelay
    // extra REQ cycles, responds rvDelay cycles into RESP, and records what
    // the BIU showed. With noise set, stray rvalid/gnt are driven where they
    // must be ignored.
    task automatic applyStimulus(input vecT v);
        int  respCycles;
        logic granted, ackSeen, done, first;
        respCycles = 0; granted = 0; ackSeen = 0; done = 0; first = 1;
        reqCycles = 0; ackCnt = 0; wrongAckCnt = 0; doneCnt = 0;
        wrongDoneCnt = 0; extraPulse = 0; latency = -1; fieldChanged = 0;
        obsAddr = '0; obsWe = 0; obsWdata = '0; obsStrb = '0;
        obsData = '0; obsErr = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                if (v.isWrite) begin
                    bus.lsu_biu_wr_req_ls2  = 1'b1;
                    bus.lsu_biu_wr_addr_ls2 = v.addr;
                    bus.lsu_biu_wr_data_ls2 = v.wdata;
                    bus.lsu_biu_wr_strb_ls2 = v.strb;
                end else begin
                    bus.lsu_biu_rd_req_ls2  = 1'b1;
                    bus.lsu_biu_rd_addr_ls2 = v.addr;
                end
            end
            if (ackSeen) begin
                bus.lsu_biu_rd_req_ls2 = 1'b0;
                bus.lsu_biu_wr_req_ls2 = 1'b0;
            end
            bus.mem_biu_gnt    = 1'b0;
            bus.mem_biu_rvalid = 1'b0;
            bus.mem_biu_rdata  = '0;
            bus.mem_biu_err    = 1'b0;
            if (bus.biu_mem_req) begin
                reqCycles++;
                if (reqCycles > v.gntDelay) bus.mem_biu_gnt = 1'b1;
                else if (v.noise) begin
                    bus.mem_biu_rvalid = 1'b1;
                    bus.mem_biu_rdata  = ~v.rdata;
                    bus.mem_biu_err    = ~v.err;
                end
            end else if (granted) begin
                respCycles++;
                if (respCycles == v.rvDelay + 1) begin
                    bus.mem_biu_rvalid = 1'b1;
                    bus.mem_biu_rdata  = v.rdata;
                    bus.mem_biu_err    = v.err;
                end else if (v.noise) bus.mem_biu_gnt = 1'b1;
            end else if (v.noise) begin
                bus.mem_biu_rvalid = 1'b1;
                bus.mem_biu_rdata  = ~v.rdata;
            end
            @(negedge clk);
            if (bus.biu_mem_req) begin
                if (!first && (obsAddr !== bus.biu_mem_addr ||
                    obsWe !== bus.biu_mem_we || obsWdata !== bus.biu_mem_wdata ||
                    obsStrb !== bus.biu_mem_wstrb)) fieldChanged = 1;
                obsAddr  = bus.biu_mem_addr;
                obsWe    = bus.biu_mem_we;
                obsWdata = bus.biu_mem_wdata;
                obsStrb  = bus.biu_mem_wstrb;
                first    = 0;
                if (bus.mem_biu_gnt) granted = 1;
            end
            if (v.isWrite ? bus.biu_lsu_wr_ack_ls2 : bus.biu_lsu_rd_ack_ls2) begin
                ackCnt++;
                ackSeen = 1;
            end
            if (v.isWrite ? bus.biu_lsu_rd_ack_ls2 : bus.biu_lsu_wr_ack_ls2)
                wrongAckCnt++;
            if (v.isWrite ? bus.biu_lsu_data_valid_ls3 : bus.biu_lsu_wr_done_ls3)
                wrongDoneCnt++;
            if (v.isWrite ? bus.biu_lsu_wr_done_ls3 : bus.biu_lsu_data_valid_ls3) begin
                doneCnt++;
                latency = c;
                obsData = bus.biu_lsu_data_ls3;
                obsErr  = v.isWrite ? bus.biu_lsu_wr_err_ls3 : bus.biu_lsu_rd_err_ls3;
                done    = 1;
            end
        end
        timedOut = !done;
        @(posedge clk); #1;
        idleInputs();
        @(negedge clk);
        if (bus.biu_lsu_data_valid_ls3 || bus.biu_lsu_wr_done_ls3 ||
            bus.biu_lsu_rd_ack_ls2 || bus.biu_lsu_wr_ack_ls2) extraPulse = 1;
    endtask

    task automatic checkTransaction(input int idx, input vecT v);
        string p;
        p = $sformatf("vec%0d", idx);
        checkOutput({p, " completes"}, 64'(timedOut), 64'd0);
        checkOutput({p, " mem_addr"}, 64'(obsAddr), 64'(v.expAddr));
        checkOutput({p, " mem_we"}, 64'(obsWe), 64'(v.isWrite));
        if (v.isWrite) begin
            checkOutput({p, " mem_wdata"}, obsWdata, v.wdata);
            checkOutput({p, " mem_wstrb"}, 64'(obsStrb), 64'(v.strb));
        end
        checkOutput({p, " fields stable"}, 64'(fieldChanged), 64'd0);
        checkOutput({p, " req cycles"}, 64'(reqCycles), 64'(v.gntDelay + 1));
        checkOutput({p, " ack pulses"}, 64'(ackCnt), 64'd1);
        checkOutput({p, " wrong ack"}, 64'(wrongAckCnt), 64'd0);
        checkOutput({p, " done pulses"}, 64'(doneCnt), 64'd1);
        checkOutput({p, " wrong done"}, 64'(wrongDoneCnt), 64'd0);
        checkOutput({p, " extra pulse"}, 64'(extraPulse), 64'd0);
        checkOutput({p, " latency"}, 64'(latency),
                    64'(v.gntDelay + v.rvDelay + 3));
        checkOutput({p, " data"}, obsData, v.expData);
        checkOutput({p, " err"}, 64'(obsErr), 64'(v.expErr));
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " mem_req"}, 64'(bus.biu_mem_req), 64'd0);
        checkOutput({name, " mem_addr"}, 64'(bus.biu_mem_addr), 64'd0);
        checkOutput({name, " mem_we"}, 64'(bus.biu_mem_we), 64'd0);
        checkOutput({name, " data"}, bus.biu_lsu_data_ls3, 64'd0);
        checkOutput({name, " pulses"},
                    64'({bus.biu_lsu_rd_ack_ls2, bus.biu_lsu_wr_ack_ls2,
                         bus.biu_lsu_data_valid_ls3, bus.biu_lsu_wr_done_ls3,
                         bus.biu_lsu_rd_err_ls3, bus.biu_lsu_wr_err_ls3}), 64'd0);
    endtask

    initial begin
        vecT rv;
        int  rdAckN, wrAckN, validN, doneN, issueN, validCycle, wrIssueCycle;
        logic inResp;
        logic [31:0] issueAddr [2];
        logic        issueWe [2];

        checks = 0;
        passes = 0;

        vecs[0] = '{0, 32'h0000_1004, 64'h0, 8'h00, 64'h1234_5678_9ABC_DEF0, 0,
                    0, 0, 0, 32'h0000_1000, 64'h1234_5678_9ABC_DEF0, 0};
        vecs[1] = '{1, 32'h0000_2002, 64'hAA_0000, 8'h04, 64'h0, 0,
                    3, 1, 0, 32'h0000_2002, 64'h1234_5678_9ABC_DEF0, 0};
        vecs[2] = '{0, 32'h0000_5FFF, 64'h0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 1,
                    1, 2, 1, 32'h0000_5FF8, 64'hDEAD_BEEF_CAFE_F00D, 1};
        vecs[3] = '{1, 32'h0000_7007, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1,
                    0, 0, 1, 32'h0000_7007, 64'hDEAD_BEEF_CAFE_F00D, 1};
        vecs[4] = '{0, 32'hFFFF_FFFF, 64'h0, 8'h00, 64'h0F0F_0F0F_A5A5_5A5A, 0,
                    2, 0, 1, 32'hFFFF_FFF8, 64'h0F0F_0F0F_A5A5_5A5A, 0};

        resetn = 1'b0;
        idleInputs();
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            checkTransaction(i, vecs[i]);
        end

        // Read and write raised together: read goes first, write is picked
        // up in the IDLE cycle that carries the read's data pulse.
        rdAckN = 0; wrAckN = 0; validN = 0; doneN = 0; issueN = 0;
        validCycle = -1; wrIssueCycle = -1; inResp = 0;
        issueAddr[0] = '0; issueAddr[1] = '0; issueWe[0] = 0; issueWe[1] = 0;
        for (int c = 0; c < 40 && !(validN > 0 && doneN > 0); c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                bus.lsu_biu_rd_req_ls2  = 1'b1;
                bus.lsu_biu_rd_addr_ls2 = 32'h0000_3000;
                bus.lsu_biu_wr_req_ls2  = 1'b1;
                bus.lsu_biu_wr_addr_ls2 = 32'h0000_4000;
                bus.lsu_biu_wr_data_ls2 = 64'h5A5A;
                bus.lsu_biu_wr_strb_ls2 = 8'h03;
            end
            if (rdAckN > 0) bus.lsu_biu_rd_req_ls2 = 1'b0;
            if (wrAckN > 0) bus.lsu_biu_wr_req_ls2 = 1'b0;
            bus.mem_biu_rvalid = inResp;
            bus.mem_biu_rdata  = 64'h5555_AAAA_5555_AAAA;
            inResp             = 0;
            bus.mem_biu_gnt    = bus.biu_mem_req;
            @(negedge clk);
            if (bus.mem_biu_gnt) begin
                inResp = 1;
                if (issueN < 2) begin
                    issueAddr[issueN] = bus.biu_mem_addr;
                    issueWe[issueN]   = bus.biu_mem_we;
                end
                if (issueN == 1) wrIssueCycle = c;
                issueN++;
            end
            if (bus.biu_lsu_rd_ack_ls2) rdAckN++;
            if (bus.biu_lsu_wr_ack_ls2) wrAckN++;
            if (bus.biu_lsu_data_valid_ls3) begin
                validN++;
                validCycle = c;
            end
            if (bus.biu_lsu_wr_done_ls3) doneN++;
        end
        @(posedge clk); #1;
        idleInputs();
        @(negedge clk);
        if (bus.biu_lsu_data_valid_ls3) validN++;
        if (bus.biu_lsu_wr_done_ls3) doneN++;
        checkOutput("both issues", 64'(issueN), 64'd2);
        checkOutput("first is read", 64'(issueWe[0]), 64'd0);
        checkOutput("first addr", 64'(issueAddr[0]), 64'h3000);
        checkOutput("second is write", 64'(issueWe[1]), 64'd1);
        checkOutput("second addr", 64'(issueAddr[1]), 64'h4000);
        checkOutput("both rd_ack", 64'(rdAckN), 64'd1);
        checkOutput("both wr_ack", 64'(wrAckN), 64'd1);
        checkOutput("both data_valid", 64'(validN), 64'd1);
        checkOutput("both wr_done", 64'(doneN), 64'd1);
        checkOutput("back-to-back write", 64'(wrIssueCycle), 64'(validCycle + 1));

        // Reset while waiting in RESP, with rvalid arriving during reset.
        @(posedge clk); #1;
        bus.lsu_biu_rd_req_ls2  = 1'b1;
        bus.lsu_biu_rd_addr_ls2 = 32'h0000_8000;
        @(posedge clk); #1;
        bus.mem_biu_gnt = 1'b1;
        @(negedge clk);
        checkOutput("rst-seq ack", 64'(bus.biu_lsu_rd_ack_ls2), 64'd1);
        @(posedge clk); #1;
        idleInputs();
        resetn             = 1'b0;
        bus.mem_biu_rvalid = 1'b1;
        bus.mem_biu_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        checkAllZero("mid-reset");
        @(posedge clk); #1;
        resetn = 1'b1;
        bus.mem_biu_rvalid = 1'b0;
        validN = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.biu_lsu_data_valid_ls3) validN++;
            if (c < 4) begin
                @(posedge clk); #1;
            end
        end
        checkOutput("post-reset no valid", 64'(validN), 64'd0);
        checkOutput("post-reset data", bus.biu_lsu_data_ls3, 64'd0);
        rv = '{0, 32'h0000_8004, 64'h0, 8'h00, 64'hCAFE_0000_BEEF_1111, 0,
               0, 0, 0, 32'h0000_8000, 64'hCAFE_0000_BEEF_1111, 0};
        applyStimulus(rv);
        checkTransaction(5, rv);

        // Granted read whose response never comes.
        validN = 0; latency = -1; obsErr = 0; obsData = '1; rdAckN = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                bus.lsu_biu_rd_req_ls2  = 1'b1;
                bus.lsu_biu_rd_addr_ls2 = 32'h0000_9000;
            end
            if (rdAckN > 0) bus.lsu_biu_rd_req_ls2 = 1'b0;
            bus.mem_biu_gnt = bus.biu_mem_req;
            @(negedge clk);
            if (bus.biu_lsu_rd_ack_ls2) rdAckN++;
            if (bus.biu_lsu_data_valid_ls3) begin
                validN++;
                latency = c;
                obsErr  = bus.biu_lsu_rd_err_ls3;
                obsData = bus.biu_lsu_data_ls3;
            end
        end
        checkOutput("noresp ack", 64'(rdAckN), 64'd1);
`ifdef C7B_BIU_TIMEOUT_EN
        checkOutput("timeout valid", 64'(validN), 64'd1);
        checkOutput("timeout latency", 64'(latency), 64'd258);
        checkOutput("timeout err", 64'(obsErr), 64'd1);
        checkOutput("timeout data", obsData, 64'd0);
`else
        checkOutput("noresp valid", 64'(validN), 64'd0);
`endif
        @(posedge clk); #1;
        idleInputs();
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
